// File: rtl/tl_wb_sequencer_if.sv
// Wishbone classic slave bundle for the traffic-light sequencer.
interface tl_wb_sequencer_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/tl_wb_sequencer.sv
// Wishbone-programmable RED/GREEN/YELLOW sequencer with pedestrian shortening and irq.
// Optional blinking-yellow FLASH mode is built when TL_FLASH_EN is defined.
module tl_wb_sequencer #(
    parameter int unsigned CNT_W       = 24,
    parameter int unsigned PED_MIN     = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n_i,
    tl_wb_sequencer_if.slave wbs,
    input  logic             ped_req_i,
    output logic             red_o,
    output logic             yellow_o,
    output logic             green_o,
    output logic [2:0]       io_oeb_o,
    output logic             irq_o
);
    localparam int unsigned DW = 32;
    localparam logic [2:0] ADR_CTRL   = 3'd0;
    localparam logic [2:0] ADR_T_RED  = 3'd1;
    localparam logic [2:0] ADR_T_GRN  = 3'd2;
    localparam logic [2:0] ADR_T_YEL  = 3'd3;
    localparam logic [2:0] ADR_STATUS = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RED    = 3'd1,
        ST_GREEN  = 3'd2,
        ST_YELLOW = 3'd3
`ifdef TL_FLASH_EN
        , ST_FLASH = 3'd4
`endif
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   t_red_q, t_red_d, t_grn_q, t_grn_d, t_yel_q, t_yel_d;
    logic [2:0]         ctrl_q, ctrl_d;
    logic               red_q, red_d, yellow_q, yellow_d, green_q, green_d;
    logic               ack_q, ack_d;
    logic [DW-1:0]      dat_q, dat_d;
    logic               irq_q, irq_d, ped_q, ped_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic               sync_prev_q;

    logic               req_c, wr_c, rd_c, enable_c, expired_c;
    logic               ped_rise_c, red_entry_c, irq_clr_c;
    logic [2:0]         adr_c;
    logic [DW-1:0]      sel_mask_c, wr_old_c, wr_val_c, rd_val_c;
    logic               unused_ok;

    assign req_c      = wbs.wbs_stb_i & wbs.wbs_cyc_i & ~ack_q;
    assign wr_c       = req_c & wbs.wbs_we_i;
    assign rd_c       = req_c & ~wbs.wbs_we_i;
    assign adr_c      = wbs.wbs_adr_i[4:2];
    assign enable_c   = ctrl_q[0];
    assign expired_c  = (cnt_q == '0);
    assign ped_rise_c = sync_q[SYNC_STAGES-1] & ~sync_prev_q;
    assign irq_clr_c  = wr_c && (adr_c == ADR_STATUS) && wbs.wbs_sel_i[0] && wbs.wbs_dat_i[3];
    assign unused_ok  = ^{wbs.wbs_adr_i[31:5], wbs.wbs_adr_i[1:0], wr_val_c[DW-1:CNT_W]};

    // Byte-lane merge of write data over the currently addressed register.
    always_comb begin
        for (int b = 0; b < 4; b++) begin
            sel_mask_c[8*b +: 8] = {8{wbs.wbs_sel_i[b]}};
        end
        case (adr_c)
            ADR_CTRL:  wr_old_c = DW'(ctrl_q);
            ADR_T_RED: wr_old_c = DW'(t_red_q);
            ADR_T_GRN: wr_old_c = DW'(t_grn_q);
            ADR_T_YEL: wr_old_c = DW'(t_yel_q);
            default:   wr_old_c = '0;
        endcase
        wr_val_c = (wr_old_c & ~sel_mask_c) | (wbs.wbs_dat_i & sel_mask_c);
    end

    always_comb begin
        ctrl_d  = ctrl_q;
        t_red_d = t_red_q;
        t_grn_d = t_grn_q;
        t_yel_d = t_yel_q;
        if (wr_c) begin
            case (adr_c)
`ifdef TL_FLASH_EN
                ADR_CTRL:  ctrl_d = wr_val_c[2:0];
`else
                ADR_CTRL:  ctrl_d = {wr_val_c[2], 1'b0, wr_val_c[0]};
`endif
                ADR_T_RED: t_red_d = wr_val_c[CNT_W-1:0];
                ADR_T_GRN: t_grn_d = wr_val_c[CNT_W-1:0];
                ADR_T_YEL: t_yel_d = wr_val_c[CNT_W-1:0];
                default:   ;
            endcase
        end
        case (adr_c)
            ADR_CTRL:   rd_val_c = DW'(ctrl_q);
            ADR_T_RED:  rd_val_c = DW'(t_red_q);
            ADR_T_GRN:  rd_val_c = DW'(t_grn_q);
            ADR_T_YEL:  rd_val_c = DW'(t_yel_q);
            ADR_STATUS: rd_val_c = DW'({ped_q, irq_q, state_q});
            default:    rd_val_c = '0;
        endcase
        ack_d = req_c;
        dat_d = rd_c ? rd_val_c : '0;
    end

    // Phase FSM: counter is loaded on phase entry, so timer writes apply at the next phase.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: if (enable_c) begin
                state_d = ST_RED;
                cnt_d   = t_red_q;
            end
            ST_RED: begin
                if (!enable_c) begin
                    state_d = ST_IDLE;
                end else if (expired_c) begin
                    state_d = ST_GREEN;
                    cnt_d   = t_grn_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_GREEN: begin
                if (!enable_c || expired_c) begin
                    state_d = ST_YELLOW;
                    cnt_d   = t_yel_q;
                end else if (ped_q && (cnt_q > CNT_W'(PED_MIN))) begin
                    cnt_d = CNT_W'(PED_MIN);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_YELLOW: begin
                if (expired_c) begin
                    state_d = enable_c ? ST_RED : ST_IDLE;
                    cnt_d   = t_red_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`ifdef TL_FLASH_EN
            ST_FLASH: cnt_d = expired_c ? t_yel_q : cnt_q - CNT_W'(1);
`endif
            default: state_d = ST_IDLE;
        endcase
`ifdef TL_FLASH_EN
        if (ctrl_q[1] && enable_c) begin
            if (state_q != ST_FLASH) begin
                state_d = ST_FLASH;
                cnt_d   = t_yel_q;
            end
        end else if (state_q == ST_FLASH) begin
            state_d = enable_c ? ST_RED : ST_IDLE;
            cnt_d   = t_red_q;
        end
`endif
        red_d    = (state_d == ST_IDLE) || (state_d == ST_RED);
        green_d  = (state_d == ST_GREEN);
        yellow_d = (state_d == ST_YELLOW);
`ifdef TL_FLASH_EN
        if (state_d == ST_FLASH) begin
            yellow_d = (state_q != ST_FLASH) ? 1'b1 : (expired_c ? ~yellow_q : yellow_q);
        end
`endif
        red_entry_c = (state_d == ST_RED) && (state_q != ST_RED);
        irq_d       = (ctrl_q[2] && red_entry_c) || (irq_q && !irq_clr_c);
        ped_d       = ped_rise_c || (ped_q && !red_entry_c);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            t_red_q     <= CNT_W'(255);
            t_grn_q     <= CNT_W'(255);
            t_yel_q     <= CNT_W'(63);
            ctrl_q      <= '0;
            red_q       <= 1'b1;
            yellow_q    <= 1'b0;
            green_q     <= 1'b0;
            ack_q       <= 1'b0;
            dat_q       <= '0;
            irq_q       <= 1'b0;
            ped_q       <= 1'b0;
            sync_q      <= '0;
            sync_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            t_red_q     <= t_red_d;
            t_grn_q     <= t_grn_d;
            t_yel_q     <= t_yel_d;
            ctrl_q      <= ctrl_d;
            red_q       <= red_d;
            yellow_q    <= yellow_d;
            green_q     <= green_d;
            ack_q       <= ack_d;
            dat_q       <= dat_d;
            irq_q       <= irq_d;
            ped_q       <= ped_d;
            sync_q      <= {sync_q[SYNC_STAGES-2:0], ped_req_i};
            sync_prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;
    assign red_o         = red_q;
    assign yellow_o      = yellow_q;
    assign green_o       = green_q;
    assign io_oeb_o      = 3'b000;
    assign irq_o         = irq_q;
endmodule

// File: tb/tb_tl_wb_sequencer.sv
// Directed + randomized bench for tl_wb_sequencer; lamp timing checked as phase run lengths.
module tb_tl_wb_sequencer;
    localparam int unsigned CNT_W       = 24;
    localparam int unsigned PED_MIN     = 16;
    localparam int unsigned SYNC_STAGES = 2;
    // samples from the first edge that sees the button until yellow shows
    localparam int PED_EXP = SYNC_STAGES + 1 + 1 + PED_MIN + 1;
    localparam logic [2:0] L_RED = 3'b100;
    localparam logic [2:0] L_YEL = 3'b010;
    localparam logic [2:0] L_GRN = 3'b001;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ped_req;
    logic       red, yellow, green, irq;
    logic [2:0] oeb;
    int         n_tests = 0;
    int         n_fail  = 0;

    logic [2:0] smp[$];
    logic [2:0] seg_col[$];
    int         seg_len[$];

    tl_wb_sequencer_if bus();

    tl_wb_sequencer #(.CNT_W(CNT_W), .PED_MIN(PED_MIN), .SYNC_STAGES(SYNC_STAGES)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .wbs        (bus.slave),
        .ped_req_i  (ped_req),
        .red_o      (red),
        .yellow_o   (yellow),
        .green_o    (green),
        .io_oeb_o   (oeb),
        .irq_o      (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [2:0] lamps();
        return {red, yellow, green};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wb_xfer(input logic [2:0] a, input logic we, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd);
        logic [31:0] junk;
        int n;
        junk = $urandom();
        bus.wbs_adr_i = {junk[31:5], a, junk[1:0]};
        bus.wbs_we_i  = we;
        bus.wbs_dat_i = d;
        bus.wbs_sel_i = s;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bus.wbs_ack_o && n < 8);
        check("ack_latency", 32'(n), 32'd1);
        rd = bus.wbs_dat_o;
        @(posedge clk); #1;
        check("ack_single_cycle", {31'd0, bus.wbs_ack_o}, 32'd0);
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
    endtask

    task automatic wb_wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] dummy;
        wb_xfer(a, 1'b1, d, s, dummy);
    endtask

    task automatic wb_rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] v;
        wb_xfer(a, 1'b0, 32'd0, 4'hF, v);
        check(tag, v, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_lamp(input string tag, input logic [2:0] pat, input int maxc);
        int n;
        n = 0;
        while (lamps() !== pat && n < maxc) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, 32'(lamps()), 32'(pat));
    endtask

    task automatic program_t(input int tr, input int tg, input int ty);
        wb_wr(3'd1, 32'(tr), 4'hF);
        wb_wr(3'd2, 32'(tg), 4'hF);
        wb_wr(3'd3, 32'(ty), 4'hF);
    endtask

    initial begin
        int tr, tg, ty, n, nsmp;
        logic [2:0] ec;
        int el;

        rst_n = 1'b0;
        ped_req = 1'b0;
        bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
        bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = 32'd0; bus.wbs_dat_i = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_lamps", 32'(lamps()), 32'(L_RED));
        check("rst_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
        check("rst_dat", bus.wbs_dat_o, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_oeb", 32'(oeb), 32'd0);
        rst_n = 1'b1;
        wb_rd_chk("rst_ctrl", 3'd0, 32'd0);
        wb_rd_chk("rst_t_red", 3'd1, 32'd255);
        wb_rd_chk("rst_t_green", 3'd2, 32'd255);
        wb_rd_chk("rst_t_yellow", 3'd3, 32'd63);
        wb_rd_chk("rst_status", 3'd4, 32'd0);

        // Phase run lengths: each phase T+1 cycles, cyclic GREEN->YELLOW->RED.
        for (int r = 0; r < 5; r++) begin
            if (r == 0) begin tr = 3; tg = 5; ty = 1; end
            else if (r == 1) begin tr = 0; tg = 0; ty = 0; end
            else begin
                tr = int'($urandom_range(7, 0));
                tg = int'($urandom_range(9, 0));
                ty = int'($urandom_range(5, 0));
            end
            do_reset();
            program_t(tr, tg, ty);
            wb_wr(3'd0, 32'd1, 4'hF);
            smp.delete();
            nsmp = 2 * (tr + tg + ty + 3) + 4;
            for (int i = 0; i < nsmp; i++) begin
                smp.push_back(lamps());
                @(posedge clk); #1;
            end
            seg_col.delete();
            seg_len.delete();
            foreach (smp[i]) begin
                if (seg_col.size() == 0 || seg_col[seg_col.size()-1] !== smp[i]) begin
                    seg_col.push_back(smp[i]);
                    seg_len.push_back(1);
                end else begin
                    seg_len[seg_len.size()-1]++;
                end
            end
            check($sformatf("r%0d_seg_count", r), 32'(seg_col.size() >= 6), 32'd1);
            for (int k = 1; k < seg_col.size() - 1; k++) begin
                case (k % 3)
                    1:       begin ec = L_GRN; el = tg + 1; end
                    2:       begin ec = L_YEL; el = ty + 1; end
                    default: begin ec = L_RED; el = tr + 1; end
                endcase
                check($sformatf("r%0d_seg%0d_col_len", r, k),
                      {13'd0, seg_col[k], 16'(seg_len[k])}, {13'd0, ec, 16'(el)});
            end
        end

        // Asynchronous reset in the middle of GREEN.
        do_reset();
        program_t(2, 30, 2);
        wb_wr(3'd0, 32'd1, 4'hF);
        wait_lamp("mg_reach_green", L_GRN, 40);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mg_async_lamps", 32'(lamps()), 32'(L_RED));
        @(posedge clk); #1;
        rst_n = 1'b1;
        wb_rd_chk("mg_status", 3'd4, 32'd0);
        wb_rd_chk("mg_t_red", 3'd1, 32'd255);

        // Enable cleared during GREEN: full YELLOW, then IDLE with red lit.
        do_reset();
        program_t(2, 20, 3);
        wb_wr(3'd0, 32'd1, 4'hF);
        wait_lamp("ec_reach_green", L_GRN, 20);
        wb_wr(3'd0, 32'd0, 4'hF);
        n = 0;
        while (lamps() === L_YEL && n < 20) begin
            n++;
            @(posedge clk); #1;
        end
        check("ec_yellow_len", 32'(n), 32'd4);
        check("ec_idle_lamp", 32'(lamps()), 32'(L_RED));
        repeat (5) @(posedge clk);
        #1;
        check("ec_idle_hold", 32'(lamps()), 32'(L_RED));
        wb_rd_chk("ec_status_idle", 3'd4, 32'd0);

        // Pedestrian request shortens a long GREEN.
        do_reset();
        program_t(2, 100, 10);
        wb_wr(3'd0, 32'd1, 4'hF);
        wait_lamp("ped_reach_green", L_GRN, 20);
        repeat (10) @(posedge clk);
        #1;
        ped_req = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 2) ped_req = 1'b0;
        end while (lamps() === L_GRN && n < 60);
        ped_req = 1'b0;
        check("ped_green_end", 32'(n), 32'(PED_EXP));
        check("ped_now_yellow", 32'(lamps()), 32'(L_YEL));
        wb_rd_chk("ped_pending_set", 3'd4, 32'h13);
        wait_lamp("ped_reach_red", L_RED, 20);
        wb_rd_chk("ped_pending_clr", 3'd4, 32'h01);

        // Interrupt on RED entry, W1C clear, and set winning over a coincident clear.
        do_reset();
        program_t(3, 3, 3);
        wb_wr(3'd0, 32'd5, 4'hF);
        check("irq_on_red_entry", {31'd0, irq}, 32'd1);
        wb_rd_chk("irq_status", 3'd4, 32'h09);
        wb_wr(3'd4, 32'h8, 4'h1);
        check("irq_w1c", {31'd0, irq}, 32'd0);
        wait_lamp("irq_reach_yellow", L_YEL, 20);
        repeat (3) @(posedge clk);
        #1;
        wb_wr(3'd4, 32'h8, 4'h1);
        check("irq_set_wins", {31'd0, irq}, 32'd1);
        check("irq_set_wins_red", 32'(lamps()), 32'(L_RED));
        wb_wr(3'd4, 32'h8, 4'h1);
        check("irq_w1c_again", {31'd0, irq}, 32'd0);

        // Byte lanes, width clipping and unmapped addresses.
        do_reset();
        wb_wr(3'd1, 32'h0012_3456, 4'hF);
        wb_wr(3'd1, 32'hAABB_CCDD, 4'h1);
        wb_rd_chk("sel_byte0", 3'd1, 32'h0012_34DD);
        wb_wr(3'd2, 32'hFFFF_FFFF, 4'hF);
        wb_rd_chk("t_green_clip", 3'd2, 32'h00FF_FFFF);
        wb_wr(3'd3, 32'hA5A5_A5A5, 4'h4);
        wb_rd_chk("sel_byte2", 3'd3, 32'h00A5_003F);
        wb_rd_chk("adr6_zero", 3'd6, 32'd0);
        wb_wr(3'd7, 32'hFFFF_FFFF, 4'hF);
        wb_rd_chk("adr7_zero", 3'd7, 32'd0);
        wb_rd_chk("ctrl_untouched", 3'd0, 32'd0);
        wb_wr(3'd0, 32'd1, 4'h0);
        wb_rd_chk("ctrl_sel_none", 3'd0, 32'd0);

        // CTRL flash bit.
        do_reset();
        wb_wr(3'd3, 32'd2, 4'hF);
        wb_wr(3'd0, 32'd3, 4'hF);
`ifdef TL_FLASH_EN
        for (int i = 0; i < 12; i++) begin
            check($sformatf("flash_lamp%0d", i), 32'(lamps()),
                  32'({1'b0, ((i / 3) % 2) == 0, 1'b0}));
            @(posedge clk); #1;
        end
        wb_rd_chk("flash_ctrl", 3'd0, 32'd3);
        wb_wr(3'd0, 32'd1, 4'hF);
        check("flash_exit_red", 32'(lamps()), 32'(L_RED));
        wb_rd_chk("flash_exit_status", 3'd4, 32'd1);
`else
        wb_rd_chk("ctrl_no_flash", 3'd0, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tl_wb_sequencer.md
Name: tl_wb_sequencer

Overview:
Wishbone-configurable traffic-light sequencer for the user project area. Sits between the Wishbone slave port and the GPIO pins: the host programs phase durations and control bits over Wishbone. The block runs the RED→GREEN→YELLOW timing FSM with pedestrian-request shortening and drives the three lamp pins plus an interrupt.

Parameters:
CNT_W, 24, width of phase duration registers and the phase down-counter (8..31)
PED_MIN, 16, GREEN cycles remaining when a pedestrian request truncates GREEN
SYNC_STAGES, 2, flops in the ped_req_i synchroniser (≥2)

Ports:
wb_clk_i  in  1  system clock
wb_rst_n_i  in  1  asynchronous active-low reset
wbs_stb_i  in  1  Wishbone strobe
wbs_cyc_i  in  1  Wishbone cycle
wbs_we_i  in  1  write enable
wbs_sel_i  in  4  byte selects
wbs_adr_i  in  32  address; only [4:2] decoded, block-select gating done by the wrapper
wbs_dat_i  in  32  write data
wbs_ack_o  out  1  acknowledge
wbs_dat_o  out  32  read data
ped_req_i  in  1  asynchronous pedestrian button (from io_in)
red_o  out  1  red lamp
yellow_o  out  1  yellow lamp
green_o  out  1  green lamp
io_oeb_o  out  3  pad output-enable-bar for the lamp pins, constant 3'b000
irq_o  out  1  cycle-start interrupt (level)

Behaviour:
- Reset is asynchronous on the wb_rst_n_i fall and released synchronously. After reset: state IDLE, red_o=1, yellow_o=0, green_o=0, wbs_ack_o=0, wbs_dat_o=0, irq_o=0, CTRL=0, T_RED=255, T_GREEN=255, T_YELLOW=63, ped_pending=0.
- Wishbone classic transfer: ack is registered and asserts 1 cycle after stb&cyc, for one cycle only. It deasserts on the next cycle even if stb stays high. A new transfer needs ack low first.
- Write: data is committed on the ack cycle, per wbs_sel_i byte lane. Read: wbs_dat_o is valid with ack and is 0 otherwise.
- Register map (adr[4:2]):
  - 0 CTRL: bit0 enable, bit1 flash (see optional feature), bit2 irq_en. Other bits read 0.
  - 1 T_RED, 2 T_GREEN, 3 T_YELLOW: CNT_W bits each; upper bits read 0.
  - 4 STATUS (RO except bit3): [2:0] state code (IDLE=0, RED=1, GREEN=2, YELLOW=3, FLASH=4), bit4 ped_pending, bit3 irq_flag. Writing 1 to bit3 clears it.
  - 5..7: read 0, writes ignored, still acked.
- Phase timing: on entering a phase, cnt←T_x. The counter decrements each cycle, and the phase exits on the cycle after cnt==0. A phase therefore lasts T_x+1 cycles; T_x=0 gives 1 cycle.
- FSM transitions:
  - IDLE: enable=1 → RED.
  - RED: expiry → GREEN.
  - GREEN: expiry → YELLOW.
  - YELLOW: expiry → RED if enable, else IDLE.
- Lamps are registered and change on the same edge as the state register. RED/IDLE: red only. GREEN: green only. YELLOW: yellow only. Exactly one lamp is lit outside FLASH.
- enable cleared mid-run:
  - RED → IDLE next cycle.
  - GREEN → YELLOW next cycle, with cnt←T_YELLOW.
  - YELLOW completes normally, then → IDLE.
- Pedestrian request:
  - ped_req_i passes through SYNC_STAGES flops, then a rising-edge detect sets ped_pending.
  - In GREEN with ped_pending=1 and cnt>PED_MIN: cnt←PED_MIN (one-shot).
  - ped_pending clears on RED entry. If set and entry coincide, set wins.
- Interrupt: irq_flag sets on every RED entry when irq_en=1. irq_o=irq_flag.
- Simultaneous irq set and W1C clear in the same cycle: set wins.
- Timer register writes take effect at the next phase entry, not mid-phase.

Optional Feature:
- Macro TL_FLASH_EN.
- Defined: CTRL.flash=1 with enable=1 forces FLASH from any state on the next cycle. In FLASH, red/green are 0 and yellow toggles every T_YELLOW+1 cycles, starting with yellow=1. Clearing flash → RED (cnt←T_RED), or → IDLE if enable=0.
- Undefined: CTRL bit1 reads 0, writes are ignored, and the FLASH state does not exist.

Test Plan:
- Reset mid-GREEN (wb_rst_n_i low for 1 cycle) → immediately red_o=1, green_o=0, STATUS state=0, T_RED reads 255.
- Write T_RED=3, T_GREEN=5, T_YELLOW=1, CTRL=1 → RED 4 cycles, GREEN 6, YELLOW 2, RED again; ack is exactly 1 cycle per access.
- T_GREEN=100, PED_MIN=16, pulse ped_req_i at GREEN cycle 10 → GREEN ends 17 cycles after the synchronised edge; ped_pending reads 1 until RED entry, then 0.
- irq_en=1 → irq_o rises on the RED entry edge; STATUS write 0x8 clears it. A clear coinciding with a RED entry leaves irq_o=1.
- Clear enable during GREEN → YELLOW for T_YELLOW+1 cycles → IDLE with red_o=1. Writes with wbs_sel_i=4'b0001 update only byte 0; a read of adr 6 returns 0 with ack.
- With TL_FLASH_EN: CTRL=3, T_YELLOW=2 → yellow toggles every 3 cycles, red/green stay 0. Without it: CTRL reads 1 after writing 3.
